// File: rtl/frame_parser_pkg.sv
// frame_parser_pkg
//   Shared definitions for the receive-side frame parser: FSM state
//   encoding, drop reason codes, the broadcast address, header field byte
//   offsets and small helper functions for field extraction and popcount.
package frame_parser_pkg;

    typedef enum logic [1:0] {
        ST_HDR0    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } fp_state_e;

    typedef enum logic [1:0] {
        DR_NONE = 2'd0,
        DR_RUNT = 2'd1,
        DR_ADDR = 2'd2,
        DR_TYPE = 2'd3
    } drop_reason_e;

    localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // Byte offsets of the header fields within their beat.
    localparam int DST_OFF    = 0;  // beat0, 6 bytes
    localparam int SRC_HI_OFF = 6;  // beat0, 2 bytes
    localparam int SRC_LO_OFF = 0;  // beat1, 4 bytes
    localparam int TYPE_OFF   = 4;  // beat1, 2 bytes
    localparam int SYNC_OFF   = 6;  // beat1, 2 bytes

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, k[i]};
        end
        return c;
    endfunction

    // Extracts nbytes (max 6) starting at byte offset off; the first wire
    // byte becomes the most significant byte. Result is right-aligned.
    function automatic logic [47:0] get_field(input logic [63:0] d,
                                              input int off,
                                              input int nbytes);
        logic [47:0] r;
        r = 48'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < nbytes) begin
                r = {r[39:0], d[8*((off + i) & 7) +: 8]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_parser_axis_out_reg.sv
// axis_out_reg
//   One-entry AXI-Stream register slice. Accepts a new beat whenever the
//   slot is empty or is being drained in the same cycle, so back-to-back
//   beats flow with no bubbles and one cycle of latency.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_*_i / s_ready_o     upstream side
//   m_*_o / m_ready_i     downstream side
module axis_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [7:0]            s_keep_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [7:0]            m_keep_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            keep_q;
    logic                  last_q;
    logic                  valid_q;

    assign s_ready_o = !valid_q || m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (s_ready_o) begin
            valid_q <= s_valid_i;
            if (s_valid_i) begin
                data_q <= s_data_i;
                keep_q <= s_keep_i;
                last_q <= s_last_i;
            end
        end
    end

    assign m_data_o  = data_q;
    assign m_keep_o  = keep_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;

endmodule

// File: rtl/frame_parser.sv
// frame_parser
//   Receives 64-bit AXI-Stream frames (two header beats + payload), checks
//   destination address, link type and sync word, strips the header and
//   forwards the payload. Reports source address, payload byte count and
//   drop reasons.
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   S_AXIS_*                      incoming frames
//   M_AXIS_*                      payload output
//   Local_Address/Link_Type/SyncWord  expected header values
//   Rx_Source_Address, Rx_Byte_Count, Frame_Done, Frame_Drop,
//   Drop_Reason, FPState          status / debug
// Optional build macro FRAME_PARSER_STATS_EN adds Stat_Accepted,
// Stat_Dropped and Stat_Runt 32-bit wrap-around event counters.
module frame_parser
    import frame_parser_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int ACCEPT_BROADCAST = 1,
    parameter int COUNT_WIDTH      = 14
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic [7:0]             S_AXIS_tkeep,
    input  logic                   S_AXIS_tvalid,
    input  logic                   S_AXIS_tlast,
    output logic                   S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]  M_AXIS_tdata,
    output logic [7:0]             M_AXIS_tkeep,
    output logic                   M_AXIS_tvalid,
    output logic                   M_AXIS_tlast,
    input  logic                   M_AXIS_tready,
    input  logic [47:0]            Local_Address,
    input  logic [15:0]            Link_Type,
    input  logic [15:0]            SyncWord,
    output logic [47:0]            Rx_Source_Address,
    output logic [COUNT_WIDTH-1:0] Rx_Byte_Count,
    output logic                   Frame_Done,
    output logic                   Frame_Drop,
    output logic [1:0]             Drop_Reason,
    output logic [1:0]             FPState
`ifdef FRAME_PARSER_STATS_EN
    ,
    output logic [31:0]            Stat_Accepted,
    output logic [31:0]            Stat_Dropped,
    output logic [31:0]            Stat_Runt
`endif
);

    fp_state_e              state_q, state_d;
    drop_reason_e           reason_q, reason_d;
    logic [47:0]            dst_q, dst_d;
    logic [15:0]            src_hi_q, src_hi_d;
    logic [47:0]            src_addr_q, src_addr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;

    logic                   out_s_valid;
    logic                   out_s_ready;

    logic [47:0]            beat_dst;
    logic [15:0]            beat_src_hi;
    logic [31:0]            beat_src_lo;
    logic [15:0]            beat_type;
    logic [15:0]            beat_sync;
    logic                   addr_ok;
    logic                   type_ok;
    logic [COUNT_WIDTH:0]   sum_w;
    logic [COUNT_WIDTH-1:0] sat_sum;

    assign beat_dst    = get_field(S_AXIS_tdata, DST_OFF, 6);
    assign beat_src_hi = 16'(get_field(S_AXIS_tdata, SRC_HI_OFF, 2));
    assign beat_src_lo = 32'(get_field(S_AXIS_tdata, SRC_LO_OFF, 4));
    assign beat_type   = 16'(get_field(S_AXIS_tdata, TYPE_OFF, 2));
    assign beat_sync   = 16'(get_field(S_AXIS_tdata, SYNC_OFF, 2));

    // Destination was captured from beat0; type/sync come from the live beat1.
    assign addr_ok = (dst_q == Local_Address) ||
                     ((ACCEPT_BROADCAST != 0) && (dst_q == BROADCAST_ADDR));
    assign type_ok = (beat_type == Link_Type) && (beat_sync == SyncWord);

    // One extra bit catches overflow so the counter sticks at all-ones.
    assign sum_w   = {1'b0, count_q} +
                     {{(COUNT_WIDTH-3){1'b0}}, popcount8(S_AXIS_tkeep)};
    assign sat_sum = sum_w[COUNT_WIDTH] ? '1 : sum_w[COUNT_WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        reason_d      = reason_q;
        dst_d         = dst_q;
        src_hi_d      = src_hi_q;
        src_addr_d    = src_addr_q;
        count_d       = count_q;
        byte_cnt_d    = byte_cnt_q;
        done_d        = 1'b0;
        drop_d        = 1'b0;
        out_s_valid   = 1'b0;
        S_AXIS_tready = 1'b1;

        case (state_q)
            ST_HDR0: begin
                if (S_AXIS_tvalid) begin
                    dst_d    = beat_dst;
                    src_hi_d = beat_src_hi;
                    if (S_AXIS_tlast) begin
                        drop_d   = 1'b1;
                        reason_d = DR_RUNT;
                    end else begin
                        state_d = ST_HDR1;
                    end
                end
            end
            ST_HDR1: begin
                if (S_AXIS_tvalid) begin
                    if (S_AXIS_tlast) begin
                        drop_d   = 1'b1;
                        reason_d = DR_RUNT;
                        state_d  = ST_HDR0;
                    end else if (!addr_ok) begin
                        drop_d   = 1'b1;
                        reason_d = DR_ADDR;
                        state_d  = ST_DROP;
                    end else if (!type_ok) begin
                        drop_d   = 1'b1;
                        reason_d = DR_TYPE;
                        state_d  = ST_DROP;
                    end else begin
                        src_addr_d = {src_hi_q, beat_src_lo};
                        count_d    = '0;
                        state_d    = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                S_AXIS_tready = out_s_ready;
                out_s_valid   = S_AXIS_tvalid;
                if (S_AXIS_tvalid && out_s_ready) begin
                    count_d = sat_sum;
                    if (S_AXIS_tlast) begin
                        byte_cnt_d = sat_sum;
                        done_d     = 1'b1;
                        state_d    = ST_HDR0;
                    end
                end
            end
            ST_DROP: begin
                if (S_AXIS_tvalid && S_AXIS_tlast) begin
                    state_d = ST_HDR0;
                end
            end
            default: state_d = ST_HDR0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_HDR0;
            reason_q   <= DR_NONE;
            dst_q      <= '0;
            src_hi_q   <= '0;
            src_addr_q <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reason_q   <= reason_d;
            dst_q      <= dst_d;
            src_hi_q   <= src_hi_d;
            src_addr_q <= src_addr_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .s_data_i (S_AXIS_tdata),
        .s_keep_i (S_AXIS_tkeep),
        .s_last_i (S_AXIS_tlast),
        .s_valid_i(out_s_valid),
        .s_ready_o(out_s_ready),
        .m_data_o (M_AXIS_tdata),
        .m_keep_o (M_AXIS_tkeep),
        .m_last_o (M_AXIS_tlast),
        .m_valid_o(M_AXIS_tvalid),
        .m_ready_i(M_AXIS_tready)
    );

    assign Rx_Source_Address = src_addr_q;
    assign Rx_Byte_Count     = byte_cnt_q;
    assign Frame_Done        = done_q;
    assign Frame_Drop        = drop_q;
    assign Drop_Reason       = reason_q;
    assign FPState           = state_q;

`ifdef FRAME_PARSER_STATS_EN
    logic [31:0] stat_acc_q;
    logic [31:0] stat_drop_q;
    logic [31:0] stat_runt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stat_acc_q  <= '0;
            stat_drop_q <= '0;
            stat_runt_q <= '0;
        end else begin
            if (done_q) begin
                stat_acc_q <= stat_acc_q + 32'd1;
            end
            if (drop_q) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
            if (drop_q && (reason_q == DR_RUNT)) begin
                stat_runt_q <= stat_runt_q + 32'd1;
            end
        end
    end

    assign Stat_Accepted = stat_acc_q;
    assign Stat_Dropped  = stat_drop_q;
    assign Stat_Runt     = stat_runt_q;
`endif

endmodule

// File: tb/tb_frame_parser.sv
// tb_frame_parser
//   Directed bench for frame_parser. Two instances share all inputs: dut
//   accepts broadcast, dut_nb does not.
module tb_frame_parser;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;
    logic [47:0] local_addr = 48'h0200_0000_0001;
    logic [15:0] link_type = 16'h88B5;
    logic [15:0] sync_word = 16'hA5A5;

    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast;
    logic [47:0] rx_src;
    logic [13:0] rx_cnt;
    logic        f_done, f_drop;
    logic [1:0]  d_reason, fp_state;

    logic        nb_s_tready;
    logic [63:0] nb_m_tdata;
    logic [7:0]  nb_m_tkeep;
    logic        nb_m_tvalid, nb_m_tlast;
    logic [47:0] nb_rx_src;
    logic [13:0] nb_rx_cnt;
    logic        nb_done, nb_drop;
    logic [1:0]  nb_reason, nb_state;
`ifdef FRAME_PARSER_STATS_EN
    logic [31:0] st_acc, st_drop, st_runt;
    logic [31:0] nb_st_acc, nb_st_drop, nb_st_runt;
`endif

    always #5 ACLK = ~ACLK;

    frame_parser #(.DATA_WIDTH(64), .ACCEPT_BROADCAST(1), .COUNT_WIDTH(14)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(s_tvalid),
        .S_AXIS_tlast(s_tlast), .S_AXIS_tready(s_tready),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tkeep(m_tkeep), .M_AXIS_tvalid(m_tvalid),
        .M_AXIS_tlast(m_tlast), .M_AXIS_tready(m_tready),
        .Local_Address(local_addr), .Link_Type(link_type), .SyncWord(sync_word),
        .Rx_Source_Address(rx_src), .Rx_Byte_Count(rx_cnt),
        .Frame_Done(f_done), .Frame_Drop(f_drop), .Drop_Reason(d_reason),
        .FPState(fp_state)
`ifdef FRAME_PARSER_STATS_EN
        , .Stat_Accepted(st_acc), .Stat_Dropped(st_drop), .Stat_Runt(st_runt)
`endif
    );

    frame_parser #(.DATA_WIDTH(64), .ACCEPT_BROADCAST(0), .COUNT_WIDTH(14)) dut_nb (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(s_tvalid),
        .S_AXIS_tlast(s_tlast), .S_AXIS_tready(nb_s_tready),
        .M_AXIS_tdata(nb_m_tdata), .M_AXIS_tkeep(nb_m_tkeep), .M_AXIS_tvalid(nb_m_tvalid),
        .M_AXIS_tlast(nb_m_tlast), .M_AXIS_tready(m_tready),
        .Local_Address(local_addr), .Link_Type(link_type), .SyncWord(sync_word),
        .Rx_Source_Address(nb_rx_src), .Rx_Byte_Count(nb_rx_cnt),
        .Frame_Done(nb_done), .Frame_Drop(nb_drop), .Drop_Reason(nb_reason),
        .FPState(nb_state)
`ifdef FRAME_PARSER_STATS_EN
        , .Stat_Accepted(nb_st_acc), .Stat_Dropped(nb_st_drop), .Stat_Runt(nb_st_runt)
`endif
    );

    // Output / event monitor (sampled on the falling edge).
    logic [63:0] mon_data [0:255];
    logic [7:0]  mon_keep [0:255];
    logic        mon_last [0:255];
    int          mon_n = 0;
    int          done_n = 0, drop_n = 0;
    int          nb_out_n = 0, nb_done_n = 0, nb_drop_n = 0;
    logic [1:0]  last_reason = 2'd0, nb_last_reason = 2'd0;

    always @(negedge ACLK) begin
        if (m_tvalid && m_tready) begin
            mon_data[mon_n & 255] <= m_tdata;
            mon_keep[mon_n & 255] <= m_tkeep;
            mon_last[mon_n & 255] <= m_tlast;
            mon_n <= mon_n + 1;
        end
        if (f_done) done_n <= done_n + 1;
        if (f_drop) begin
            drop_n      <= drop_n + 1;
            last_reason <= d_reason;
        end
        if (nb_m_tvalid && m_tready) nb_out_n <= nb_out_n + 1;
        if (nb_done) nb_done_n <= nb_done_n + 1;
        if (nb_drop) begin
            nb_drop_n      <= nb_drop_n + 1;
            nb_last_reason <= nb_reason;
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int stall_n = 0;
    int b_out, b_done, b_drop, b_nbout, b_nbdone, b_nbdrop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mk_hdr0(input logic [47:0] dst, input logic [15:0] src_hi);
        logic [63:0] d;
        for (int k = 0; k < 6; k++) d[8*k +: 8] = dst[8*(5-k) +: 8];
        d[55:48] = src_hi[15:8];
        d[63:56] = src_hi[7:0];
        return d;
    endfunction

    function automatic logic [63:0] mk_hdr1(input logic [31:0] src_lo, input logic [15:0] typ,
                                            input logic [15:0] syn);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = src_lo[8*(3-k) +: 8];
        d[39:32] = typ[15:8];
        d[47:40] = typ[7:0];
        d[55:48] = syn[15:8];
        d[63:56] = syn[7:0];
        return d;
    endfunction

    // Presents one beat and holds it until the handshake (bounded).
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit hs;
        int guard;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        hs = 0; guard = 0;
        while (!hs) begin
            @(negedge ACLK);
            if (!s_tready) stall_n++;
            hs = s_tready;
            @(posedge ACLK); #1;
            guard++;
            if (!hs && guard > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout: observed no tready expected tready within 100 cycles");
                hs = 1;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] syn,
                            input logic runt);
        send_beat(mk_hdr0(dst, src[47:32]), 8'hFF, 1'b0);
        send_beat(mk_hdr1(src[31:0], 16'h88B5, syn), 8'hFF, runt);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic snap();
        b_out = mon_n; b_done = done_n; b_drop = drop_n;
        b_nbout = nb_out_n; b_nbdone = nb_done_n; b_nbdrop = nb_drop_n;
        stall_n = 0;
    endtask

    localparam logic [47:0] SRC9 = 48'h0200_0000_0009;
    localparam logic [47:0] ME   = 48'h0200_0000_0001;

    initial begin
        // Reset state
        idle(3);
        @(negedge ACLK);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_frame_done", 64'(f_done), 64'd0);
        check("rst_frame_drop", 64'(f_drop), 64'd0);
        check("rst_drop_reason", 64'(d_reason), 64'd0);
        check("rst_byte_count", 64'(rx_cnt), 64'd0);
        check("rst_src_addr", 64'(rx_src), 64'd0);
        check("rst_fpstate", 64'(fp_state), 64'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        idle(2);
        check("idle_s_tready", 64'(s_tready), 64'd1);

        // Matching frame, 3 payload beats FF/FF/0F -> 20 bytes
        snap();
        send_hdr(ME, SRC9, 16'hA5A5, 1'b0);
        send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        send_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0);
        send_beat(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1);
        idle(4);
        check("match_out_beats", 64'(mon_n - b_out), 64'd3);
        check("match_beat0_data", mon_data[b_out & 255], 64'h1111_2222_3333_4444);
        check("match_beat1_data", mon_data[(b_out + 1) & 255], 64'h5555_6666_7777_8888);
        check("match_beat2_data", mon_data[(b_out + 2) & 255], 64'h0000_0000_DEAD_BEEF);
        check("match_beat2_keep", 64'(mon_keep[(b_out + 2) & 255]), 64'h0F);
        check("match_beat1_last", 64'(mon_last[(b_out + 1) & 255]), 64'd0);
        check("match_beat2_last", 64'(mon_last[(b_out + 2) & 255]), 64'd1);
        check("match_byte_count", 64'(rx_cnt), 64'd20);
        check("match_done_pulses", 64'(done_n - b_done), 64'd1);
        check("match_src_addr", 64'(rx_src), 64'h0200_0000_0009);
        check("match_no_drop", 64'(drop_n - b_drop), 64'd0);
        check("nb_match_done", 64'(nb_done_n - b_nbdone), 64'd1);

        // Wrong destination -> drop reason 2, no output, tready stays high
        snap();
        send_hdr(48'h0200_0000_0002, SRC9, 16'hA5A5, 1'b0);
        send_beat(64'hAAAA, 8'hFF, 1'b0);
        send_beat(64'hBBBB, 8'hFF, 1'b1);
        idle(4);
        check("addr_out_beats", 64'(mon_n - b_out), 64'd0);
        check("addr_stalls", 64'(stall_n), 64'd0);
        check("addr_drop_pulses", 64'(drop_n - b_drop), 64'd1);
        check("addr_drop_reason", 64'(last_reason), 64'd2);
        check("addr_reason_held", 64'(d_reason), 64'd2);
        check("addr_src_unchanged", 64'(rx_src), 64'h0200_0000_0009);

        // Broadcast destination: accepted by dut, dropped by dut_nb
        snap();
        send_hdr(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0007, 16'hA5A5, 1'b0);
        send_beat(64'hC0C0, 8'hFF, 1'b0);
        send_beat(64'hD0D0, 8'hA5, 1'b1);
        idle(4);
        check("bcast_out_beats", 64'(mon_n - b_out), 64'd2);
        check("bcast_keep_nc", 64'(mon_keep[(b_out + 1) & 255]), 64'hA5);
        check("bcast_byte_count", 64'(rx_cnt), 64'd12);
        check("bcast_src_addr", 64'(rx_src), 64'h0200_0000_0007);
        check("nb_bcast_out", 64'(nb_out_n - b_nbout), 64'd0);
        check("nb_bcast_drop", 64'(nb_drop_n - b_nbdrop), 64'd1);
        check("nb_bcast_reason", 64'(nb_last_reason), 64'd2);

        // Sync mismatch -> reason 3
        snap();
        send_hdr(ME, SRC9, 16'h5A5A, 1'b0);
        send_beat(64'hEEEE, 8'hFF, 1'b1);
        idle(4);
        check("sync_out_beats", 64'(mon_n - b_out), 64'd0);
        check("sync_drop_reason", 64'(last_reason), 64'd3);
        check("sync_drop_pulses", 64'(drop_n - b_drop), 64'd1);

        // Runt: tlast on beat1, then on beat0, then a valid 1-beat frame
        snap();
        send_hdr(ME, SRC9, 16'hA5A5, 1'b1);
        idle(3);
        check("runt1_drop_reason", 64'(last_reason), 64'd1);
        check("runt1_out_beats", 64'(mon_n - b_out), 64'd0);
        check("runt1_no_done", 64'(done_n - b_done), 64'd0);
        send_beat(mk_hdr0(ME, 16'h0200), 8'hFF, 1'b1);
        idle(3);
        check("runt0_drop_pulses", 64'(drop_n - b_drop), 64'd2);
        send_hdr(ME, SRC9, 16'hA5A5, 1'b0);
        send_beat(64'h0123_4567_89AB_CDEF, 8'h03, 1'b1);
        idle(4);
        check("post_runt_out", 64'(mon_n - b_out), 64'd1);
        check("post_runt_data", mon_data[b_out & 255], 64'h0123_4567_89AB_CDEF);
        check("post_runt_count", 64'(rx_cnt), 64'd2);
        check("post_runt_done", 64'(done_n - b_done), 64'd1);

        // Backpressure: M tready low 5 cycles mid 10-beat payload
        snap();
        fork
            begin
                send_hdr(ME, SRC9, 16'hA5A5, 1'b0);
                for (int i = 0; i < 10; i++) send_beat(64'h100 + 64'(i), 8'hFF, (i == 9));
            end
            begin
                repeat (5) @(posedge ACLK);
                #1 m_tready = 1'b0;
                repeat (5) @(posedge ACLK);
                #1 m_tready = 1'b1;
            end
        join
        idle(4);
        check("bp_stall_cycles", 64'(stall_n), 64'd5);
        check("bp_out_beats", 64'(mon_n - b_out), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_beat%0d_data", i), mon_data[(b_out + i) & 255], 64'h100 + 64'(i));
            check($sformatf("bp_beat%0d_last", i), 64'(mon_last[(b_out + i) & 255]), 64'(i == 9));
        end
        check("bp_byte_count", 64'(rx_cnt), 64'd80);

        // Reset mid-payload
        send_hdr(ME, SRC9, 16'hA5A5, 1'b0);
        send_beat(64'hF1, 8'hFF, 1'b0);
        send_beat(64'hF2, 8'hFF, 1'b0);
        check("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        ARESETN = 1'b0;
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_fpstate", 64'(fp_state), 64'd0);
        check("midrst_byte_count", 64'(rx_cnt), 64'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        idle(2);
        snap();
        send_hdr(ME, SRC9, 16'hA5A5, 1'b0);
        send_beat(64'hA1, 8'hFF, 1'b0);
        send_beat(64'hA2, 8'hFF, 1'b0);
        send_beat(64'hA3, 8'hFF, 1'b1);
        idle(4);
        check("postrst_out_beats", 64'(mon_n - b_out), 64'd3);
        check("postrst_byte_count", 64'(rx_cnt), 64'd24);
        check("postrst_done", 64'(done_n - b_done), 64'd1);
        check("postrst_src_addr", 64'(rx_src), 64'h0200_0000_0009);
`ifdef FRAME_PARSER_STATS_EN
        check("stat_accepted", 64'(st_acc), 64'd1);
        check("stat_dropped", 64'(st_drop), 64'd0);
        check("stat_runt", 64'(st_runt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
